// File: rtl/nibble_pkg.sv
// Shared definitions for the serial nibble adder: FSM encoding, slice width
// and the nibble-counter width helper.
package nibble_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIBBLE_W = 4;

   // Smallest w with 2**w >= nibbles; nibbles is at least 2, so w >= 1.
   function automatic int cnt_width(input int nibbles);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < nibbles) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/adder_4bit.sv
// Combinational 4-bit ripple-carry adder built from four full-adder cells.
module adder_4bit (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_sum,
   output logic       o_cout
);

   logic [4:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar g = 0; g < 4; g++) begin : g_fa
      assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
   end

   assign o_cout = w_c[4];

endmodule

// File: rtl/serial_nibble_adder.sv
// Wide adder that reuses one 4-bit ripple slice, one nibble per clock,
// least-significant nibble first, with valid/ready on both sides.
module serial_nibble_adder
   import nibble_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
   input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
   input  logic                       in_cin,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
   output logic                       out_cout,
   output logic                       out_ovf,
   output logic [1:0]                 o_dbg_state
);

   // Handshake rule on both ports: a transfer happens on a rising edge where
   // valid and ready are both high; neither side depends combinationally on
   // the other, and the producer holds its data stable until the transfer.

   localparam int W  = NIBBLE_W * NIBBLES;
   localparam int CW = cnt_width(NIBBLES);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_sum;
   logic            r_carry;
   logic            r_cout;
   logic            r_ovf;
   logic [CW-1:0]   r_cnt;

   logic [CW+1:0]   w_base;
   logic [3:0]      w_nib_a;
   logic [3:0]      w_nib_b;
   logic [3:0]      w_nib_sum;
   logic            w_nib_cout;
   logic            w_last;

   assign w_base  = {r_cnt, 2'b00};
   assign w_nib_a = r_a[w_base +: NIBBLE_W];
   assign w_nib_b = r_b[w_base +: NIBBLE_W];
   assign w_last  = (r_cnt == CW'(NIBBLES - 1));

   adder_4bit u_adder (
      .i_a    (w_nib_a),
      .i_b    (w_nib_b),
      .i_cin  (r_carry),
      .o_sum  (w_nib_sum),
      .o_cout (w_nib_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_nxt = BUSY;
         BUSY:    if (w_last)    w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default:                w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_carry <= in_cin;
                  r_cnt   <= '0;
               end
            end
            BUSY: begin
               r_sum[w_base +: NIBBLE_W] <= w_nib_sum;
               r_carry                   <= w_nib_cout;
               r_cnt                     <= r_cnt + CW'(1);
               // Top slice: its sum MSB is the result sign bit.
               if (w_last) begin
                  r_cout <= w_nib_cout;
                  r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_nib_sum[3] != r_a[W-1]);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready    = (r_state == IDLE);
   assign out_valid   = (r_state == DONE);
   assign out_sum     = r_sum;
   assign out_cout    = r_cout;
   assign out_ovf     = r_ovf;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Scoreboard bench for serial_nibble_adder: directed vectors, backpressure,
// mid-operation reset and a random stream against a reference add.
module tb_serial_nibble_adder;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          in_cin = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_ovf;
   logic [1:0]    dbg_state;

   int            checks = 0;
   int            errors = 0;
   bit            rand_mode = 1'b0;
   bit            ready_force = 1'b1;

   // Expected entries are {cout, ovf, sum}.
   logic [W+1:0]  exp_q[$];

   serial_nibble_adder #(.NIBBLES(NIBBLES)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_cin      (in_cin),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .out_cout    (out_cout),
      .out_ovf     (out_ovf),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
   end

   // ---------------- reference model ----------------
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
      logic [W:0] s;
      logic       ovf;
      s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      return {s[W], ovf, s[W-1:0]};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W+1:0] exp);
      int n;
      n        = 0;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready=%b after %0d cycles", in_ready, n);
      end else begin
         exp_q.push_back(exp);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_in_ready"},  (W+2)'(in_ready),  (W+2)'(1));
      check({name, "_out_valid"}, (W+2)'(out_valid), (W+2)'(0));
      check({name, "_outputs"},   {out_cout, out_ovf, out_sum}, '0);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [W+1:0] exp;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %h with no pending operation",
                     {out_cout, out_ovf, out_sum});
         end else begin
            exp = exp_q.pop_front();
            check("result", {out_cout, out_ovf, out_sum}, exp);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;

      #2;
      check_reset_state("reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic add plus latency: counting the accept edge, out_valid appears
      // after NIBBLES+1 edges, i.e. NIBBLES edges after the accept edge.
      send_op(16'h1234, 16'h4321, 1'b0, 18'h05555);
      check("busy_in_ready", (W+2)'(in_ready), (W+2)'(0));
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!out_valid && n < 20);
      check("latency_edges", (W+2)'(n), (W+2)'(NIBBLES));

      send_op(16'hFFFF, 16'h0001, 1'b0, 18'h20000);
      send_op(16'h7FFF, 16'h0001, 1'b0, 18'h18000);
      send_op(16'h0000, 16'h0000, 1'b1, 18'h00001);
      drain("directed");

      // Backpressure: result held, new operands offered but not taken.
      ready_force = 1'b0;
      @(posedge clk);
      #1;
      send_op(16'h8000, 16'h8000, 1'b0, 18'h30000);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 20);
      in_a     = 16'hA5A5;
      in_b     = 16'h5A5A;
      in_cin   = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("hold_out_valid", (W+2)'(out_valid), (W+2)'(1));
         check("hold_in_ready",  (W+2)'(in_ready),  (W+2)'(0));
         check("hold_outputs",   {out_cout, out_ovf, out_sum}, 18'h30000);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      ready_force = 1'b1;
      send_op(16'hA5A5, 16'h5A5A, 1'b1, 18'h20000);
      drain("backpressure");

      // Reset in the middle of BUSY with the counter at 2.
      send_op(16'h1111, 16'h2222, 1'b0, 18'h03333);
      @(posedge clk);
      @(posedge clk);
      #3;
      check("mid_state_busy", (W+2)'(dbg_state), (W+2)'(1));
      rst_n = 1'b0;
      #1;
      check_reset_state("mid_reset");
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_op(16'h00FF, 16'h0001, 1'b0, 18'h00100);
      drain("post_reset");

      // Random stream with random out_ready.
      rand_mode = 1'b1;
      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom_range(0, 16'hFFFF));
         rb = W'($urandom_range(0, 16'hFFFF));
         rc = 1'($urandom_range(0, 1));
         send_op(ra, rb, rc, model(ra, rb, rc));
      end
      rand_mode = 1'b0;
      drain("stream");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $finish;
   end

endmodule
